biquad_single: RTL and testbench

Single second-order IIR section (biquad) for signed fixed-point sample streams in the filter chain. It implements Direct Form I with coefficients fixed at elaboration from real-valued parameters. Each accepted input sample produces one output sample. Multiple instances are used side by side, for example one per I/Q rail, sharing strobe timing.

---
 rtl/biquad_single.sv | 141 ++++++++++++++
 tb/tb_biquad_single.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/biquad_single.sv
// Direct Form I biquad with elaboration-time quantized coefficients and 1-cycle latency.
// Optional output/feedback saturation is enabled by defining BIQUAD_SINGLE_SATURATE_EN.
module biquad_single #(
    parameter int unsigned WIDTH_D  = 18,
    parameter int unsigned WIDTH_C  = 18,
    parameter real         COEFF_B0 = 0.0,
    parameter real         COEFF_B1 = 0.0,
    parameter real         COEFF_B2 = 0.0,
    parameter real         COEFF_A1 = 0.0,
    parameter real         COEFF_A2 = 0.0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inStrobe,
    input  logic signed [WIDTH_D-1:0] dataIn,
    output logic                      outStrobe,
    output logic signed [WIDTH_D-1:0] dataOut
);

    localparam int unsigned PROD_W = WIDTH_D + WIDTH_C;
    localparam int unsigned ACC_W  = PROD_W + 3;
    localparam int unsigned FRAC   = WIDTH_C - 2;

    function automatic bit in_range(input real c);
        return (c >= -2.0) && (c < 2.0);
    endfunction

    // Round half away from zero; values just under 2.0 that round up are pinned to the top code.
    function automatic logic signed [WIDTH_C-1:0] quantize(input real c);
        real    s;
        longint q;
        longint q_max;
        s = c * (2.0 ** FRAC);
        if (s >= 0.0) begin
            q = longint'($floor(s + 0.5));
        end else begin
            q = -longint'($floor(-s + 0.5));
        end
        q_max = (longint'(1) <<< (WIDTH_C - 1)) - 1;
        if (q > q_max) begin
            q = q_max;
        end
        return q[WIDTH_C-1:0];
    endfunction

    localparam bit COEFF_OK = in_range(COEFF_B0) && in_range(COEFF_B1) && in_range(COEFF_B2) &&
                              in_range(COEFF_A1) && in_range(COEFF_A2);

    if (!COEFF_OK) begin : g_coeff_range_error
        $error("biquad_single: every COEFF must lie in [-2.0, 2.0)");
    end

    localparam logic signed [WIDTH_C-1:0] C_B0 = quantize(COEFF_B0);
    localparam logic signed [WIDTH_C-1:0] C_B1 = quantize(COEFF_B1);
    localparam logic signed [WIDTH_C-1:0] C_B2 = quantize(COEFF_B2);
    localparam logic signed [WIDTH_C-1:0] C_A1 = quantize(COEFF_A1);
    localparam logic signed [WIDTH_C-1:0] C_A2 = quantize(COEFF_A2);

    localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] RND = ONE <<< (WIDTH_C - 3);
`ifdef BIQUAD_SINGLE_SATURATE_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = (ONE <<< (WIDTH_D - 1)) - ONE;
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
`endif

    logic                      in_strobe_q, in_strobe_d;
    logic signed [WIDTH_D-1:0] data_in_q, data_in_d;
    logic signed [WIDTH_D-1:0] x1_q, x1_d, x2_q, x2_d;
    logic signed [WIDTH_D-1:0] y1_q, y1_d, y2_q, y2_d;
    logic                      out_strobe_q, out_strobe_d;

    logic signed [PROD_W-1:0]  prod_b0, prod_b1, prod_b2, prod_a1, prod_a2;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [WIDTH_D-1:0] y_res;

    // Single-cycle datapath from the captured sample and the current state.
    always_comb begin
        prod_b0 = PROD_W'(data_in_q) * PROD_W'(C_B0);
        prod_b1 = PROD_W'(x1_q) * PROD_W'(C_B1);
        prod_b2 = PROD_W'(x2_q) * PROD_W'(C_B2);
        prod_a1 = PROD_W'(y1_q) * PROD_W'(C_A1);
        prod_a2 = PROD_W'(y2_q) * PROD_W'(C_A2);
        acc     = ACC_W'(prod_b0) + ACC_W'(prod_b1) + ACC_W'(prod_b2)
                - ACC_W'(prod_a1) - ACC_W'(prod_a2);
        shifted = (acc + RND) >>> FRAC;
`ifdef BIQUAD_SINGLE_SATURATE_EN
        if (shifted > Y_MAX) begin
            y_res = {1'b0, {(WIDTH_D - 1){1'b1}}};
        end else if (shifted < Y_MIN) begin
            y_res = {1'b1, {(WIDTH_D - 1){1'b0}}};
        end else begin
            y_res = WIDTH_D'(shifted);
        end
`else
        y_res = WIDTH_D'(shifted);
`endif
    end

    always_comb begin
        in_strobe_d  = inStrobe;
        data_in_d    = inStrobe ? dataIn : data_in_q;
        x1_d         = x1_q;
        x2_d         = x2_q;
        y1_d         = y1_q;
        y2_d         = y2_q;
        out_strobe_d = 1'b0;
        if (in_strobe_q) begin
            x2_d         = x1_q;
            x1_d         = data_in_q;
            y2_d         = y1_q;
            y1_d         = y_res;
            out_strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_strobe_q  <= 1'b0;
            data_in_q    <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            y1_q         <= '0;
            y2_q         <= '0;
            out_strobe_q <= 1'b0;
        end else begin
            in_strobe_q  <= in_strobe_d;
            data_in_q    <= data_in_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            y1_q         <= y1_d;
            y2_q         <= y2_d;
            out_strobe_q <= out_strobe_d;
        end
    end

    // y1 is always the most recent output, so it doubles as the held output register.
    assign dataOut   = y1_q;
    assign outStrobe = out_strobe_q;

endmodule

// File: tb/tb_biquad_single.sv
// Randomized and directed bench for biquad_single against an integer reference model.
module tb_biquad_single;

    localparam int N = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_strobe;
    logic signed [17:0] data_in;
    logic              ostb [N];
    logic signed [17:0] dout [N];

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;

    // Quantized coefficients worked out by hand: pass, recursion, FIR, low-pass, saturation, mixed.
    longint qb0 [N] = '{32768, 65536, 16384, 8, 124518, 45875};
    longint qb1 [N] = '{0, 0, 16384, 16, 0, -85197};
    longint qb2 [N] = '{0, 0, 16384, 8, 0, 29491};
    longint qa1 [N] = '{0, -32768, 0, -129712, 0, -39322};
    longint qa2 [N] = '{0, 0, 0, 64221, 0, 19661};

    longint mx1 [N];
    longint mx2 [N];
    longint my1 [N];
    longint my2 [N];

    longint due_q [$];
    longint y_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    biquad_single #(.COEFF_B0(0.5)) u_pass (
        .clk(clk), .rst(rst), .inStrobe(in_strobe), .dataIn(data_in),
        .outStrobe(ostb[0]), .dataOut(dout[0]));
    biquad_single #(.COEFF_B0(1.0), .COEFF_A1(-0.5)) u_rec (
        .clk(clk), .rst(rst), .inStrobe(in_strobe), .dataIn(data_in),
        .outStrobe(ostb[1]), .dataOut(dout[1]));
    biquad_single #(.COEFF_B0(0.25), .COEFF_B1(0.25), .COEFF_B2(0.25)) u_fir (
        .clk(clk), .rst(rst), .inStrobe(in_strobe), .dataIn(data_in),
        .outStrobe(ostb[2]), .dataOut(dout[2]));
    biquad_single #(.COEFF_B0(1.22422e-4), .COEFF_B1(2.44844e-4), .COEFF_B2(1.22422e-4),
                    .COEFF_A1(-1.97925), .COEFF_A2(0.97994)) u_lp (
        .clk(clk), .rst(rst), .inStrobe(in_strobe), .dataIn(data_in),
        .outStrobe(ostb[3]), .dataOut(dout[3]));
    biquad_single #(.COEFF_B0(1.9)) u_sat (
        .clk(clk), .rst(rst), .inStrobe(in_strobe), .dataIn(data_in),
        .outStrobe(ostb[4]), .dataOut(dout[4]));
    biquad_single #(.COEFF_B0(0.7), .COEFF_B1(-1.3), .COEFF_B2(0.45),
                    .COEFF_A1(-0.6), .COEFF_A2(0.3)) u_mix (
        .clk(clk), .rst(rst), .inStrobe(in_strobe), .dataIn(data_in),
        .outStrobe(ostb[5]), .dataOut(dout[5]));

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Difference equation on plain integers: scale 2^16, round half up, then clamp or wrap to 18b.
    function automatic longint model_step(input int i, input longint x);
        longint acc;
        longint r;
        longint y;
        acc = qb0[i] * x + qb1[i] * mx1[i] + qb2[i] * mx2[i] - qa1[i] * my1[i] - qa2[i] * my2[i];
        r = (acc + 32768) >>> 16;
`ifdef BIQUAD_SINGLE_SATURATE_EN
        y = (r > 131071) ? 131071 : ((r < -131072) ? -131072 : r);
`else
        y = ((r + 131072) & 262143) - 131072;
`endif
        mx2[i] = mx1[i];
        mx1[i] = x;
        my2[i] = my1[i];
        my1[i] = y;
        return y;
    endfunction

    function automatic longint rand18();
        logic signed [17:0] r;
        r = 18'($urandom);
        return longint'(r);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mx1[i] = 0;
            mx2[i] = 0;
            my1[i] = 0;
            my2[i] = 0;
        end
        // Outputs not yet registered when reset is sampled are lost.
        while (due_q.size() > 0 && due_q[$] > cyc) begin
            void'(due_q.pop_back());
            for (int i = 0; i < N; i++) void'(y_q.pop_back());
        end
    endtask

    // Called just after a negedge; returns on a negedge `gap` cycles later.
    task automatic send(input longint x, input int gap);
        in_strobe = 1'b1;
        data_in   = 18'(x);
        due_q.push_back(cyc + 2);
        for (int i = 0; i < N; i++) y_q.push_back(model_step(i, x));
        @(negedge clk);
        in_strobe = 1'b0;
        data_in   = 18'($urandom);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        in_strobe = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        bit exp_s;
        exp_s = (due_q.size() > 0) && (due_q[0] == cyc);
        for (int i = 0; i < N; i++) check($sformatf("out_strobe[%0d]", i), longint'(ostb[i]),
                                          longint'(exp_s));
        if (exp_s) begin
            void'(due_q.pop_front());
            for (int i = 0; i < N; i++) check($sformatf("data_out[%0d]", i), dout[i],
                                              y_q.pop_front());
        end
    end

    initial begin
        longint exp_rec [6];
        longint exp_fir [4];
        longint fir_in [4];
        rst       = 1'b1;
        in_strobe = 1'b0;
        data_in   = '0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) check("reset_dout", dout[i], 0);

        send(1000, 4);
        check("pass_pos", dout[0], 500);
        send(-1001, 4);
        check("pass_neg_half_up", dout[0], -500);

        apply_reset();
        exp_rec = '{1000, 500, 250, 125, 63, 32};
        for (int k = 0; k < 6; k++) begin
            send((k == 0) ? 1000 : 0, 4);
            check("recursion", dout[1], exp_rec[k]);
        end

        apply_reset();
        fir_in  = '{4000, 0, 0, 0};
        exp_fir = '{1000, 1000, 1000, 0};
        for (int k = 0; k < 4; k++) begin
            send(fir_in[k], 4);
            check("fir", dout[2], exp_fir[k]);
        end

        apply_reset();
        send(131071, 4);
`ifdef BIQUAD_SINGLE_SATURATE_EN
        check("saturate", dout[4], 131071);
`else
        check("wrap", dout[4], -13110);
`endif

        // Reset one cycle after a strobe drops the pending output.
        apply_reset();
        send(5000, 1);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        check("drop_strobe", longint'(ostb[0]), 0);
        check("drop_dout", dout[0], 0);
        send(1000, 4);
        check("after_rst_pass", dout[0], 500);
        check("after_rst_rec", dout[1], 1000);

        // A strobe coinciding with reset is discarded.
        rst       = 1'b1;
        in_strobe = 1'b1;
        data_in   = 18'sd7777;
        model_clear();
        @(negedge clk);
        rst       = 1'b0;
        in_strobe = 1'b0;
        repeat (3) @(negedge clk);
        check("coincide_dout", dout[2], 0);

        apply_reset();
        repeat (600) send(rand18(), int'($urandom_range(1, 3)));

        apply_reset();
        repeat (4000) send(100000, 4);
        check("lowpass_dc_in_band", longint'(dout[3] >= 70400 && dout[3] <= 71822), 1);

        repeat (4) @(negedge clk);
        check("queue_drained", due_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
